// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised simple-dual-port RAM.
// Holds the clear-sequencer state type, the byte width and the even-parity helper
// used when the RAM_PARITY_EN build option is enabled.
package ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  // Even-parity bit for one byte: storing this alongside the byte makes the
  // XOR of all nine bits zero.
  function automatic logic parity8(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer for ram_sdp_param.
// After reset it walks every address once, requesting a zero write per cycle,
// then parks in ST_READY until the next reset. init_busy is registered and
// drops on the same edge that enters ST_READY.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        state_r;
  ram_state_t        state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_s;
  logic              busy_r;

  // Next-state and clear-write request decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    clr_we  = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_READY;
          cnt_s   = {ADDR_W{1'b0}};
        end else begin
          cnt_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_READY: begin
        state_s = ST_READY;
      end
      default: begin
        state_s = ST_CLEAR;
        cnt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, counter and busy flag registers; reset restarts the clear at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == ST_CLEAR);
    end
  end

  assign clr_addr  = cnt_r;
  assign init_busy = busy_r;

endmodule

// File: rtl/ram_sdp_param.sv
// Parametrised single-clock simple-dual-port RAM with byte enables, a registered
// read port with a valid pulse, and a clear sequencer that zeroes every word
// after reset. Reads are read-first on an address collision.
// Build option: define RAM_PARITY_EN to store an even-parity bit per byte and
// flag a parity error alongside each read; otherwise parity_err is tied low.
module ram_sdp_param
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     init_busy,
  output logic                     parity_err
);

  localparam int NB = DATA_W / BYTE_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + NB;
`else
  localparam int MEM_W = DATA_W;
`endif
  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  generate
    if ((DATA_W % BYTE_W) != 0) begin : g_bad_data_w
      $error("ram_sdp_param: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("ram_sdp_param: DEPTH must be at least 2");
    end
  endgenerate

  // Plain array without reset so synthesis can map it onto block RAM.
  logic [MEM_W-1:0] mem_r [DEPTH];

  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;

  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [NB-1:0]     wbe_s;
  logic [MEM_W-1:0]  wword_s;
  logic [MEM_W-1:0]  rword_s;
  logic              wr_in_range_s;
  logic              rd_in_range_s;

  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;

  ram_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (busy_s),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s)
  );

  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_X);

  // Write-port mux: the clear sequencer owns the port while busy, user writes otherwise.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = wr_addr;
    wdata_s = wr_data;
    wbe_s   = wr_be;
    if (clr_we_s) begin
      we_s    = 1'b1;
      waddr_s = clr_addr_s;
      wdata_s = {DATA_W{1'b0}};
      wbe_s   = {NB{1'b1}};
    end else if (!busy_s && wr_en && wr_in_range_s) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Stored word image: data bytes plus, when enabled, one parity bit per byte above them.
  always_comb begin
    wword_s = {MEM_W{1'b0}};
    for (int i = 0; i < NB; i++) begin
      wword_s[i*BYTE_W +: BYTE_W] = wdata_s[i*BYTE_W +: BYTE_W];
`ifdef RAM_PARITY_EN
      wword_s[DATA_W + i] = parity8(wdata_s[i*BYTE_W +: BYTE_W]);
`endif
    end
  end

  // Byte-masked array write; a byte's parity bit travels with its enable.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe_s[i]) begin
          mem_r[waddr_s][i*BYTE_W +: BYTE_W] <= wword_s[i*BYTE_W +: BYTE_W];
`ifdef RAM_PARITY_EN
          mem_r[waddr_s][DATA_W + i] <= wword_s[DATA_W + i];
`endif
        end
      end
    end
  end

  assign rword_s = mem_r[rd_addr];

`ifdef RAM_PARITY_EN
  logic perr_s;
  logic perr_r;

  // Any byte whose nine stored bits do not XOR to zero is a parity failure.
  always_comb begin
    perr_s = 1'b0;
    for (int i = 0; i < NB; i++) begin
      perr_s = perr_s | (parity8(rword_s[i*BYTE_W +: BYTE_W]) ^ rword_s[DATA_W + i]);
    end
  end

  // Parity flag is registered alongside the read data and only set with rd_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_r <= 1'b0;
    end else if (!busy_s && rd_en && rd_in_range_s) begin
      perr_r <= perr_s;
    end else begin
      perr_r <= 1'b0;
    end
  end

  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

  // Registered read port: old word on collision, zero for out-of-range, data held when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (!busy_s && rd_en) begin
      rd_valid_r <= 1'b1;
      if (rd_in_range_s) begin
        rd_data_r <= rword_s[DATA_W-1:0];
      end else begin
        rd_data_r <= {DATA_W{1'b0}};
      end
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign init_busy = busy_s;

endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench for ram_sdp_param: an 8-bit x 16 instance and a 32-bit x 12
// instance (non-power-of-2 depth for out-of-range addresses). Inputs change
// 1 ns after the rising edge; outputs are checked at that same point, i.e.
// they reflect the edge just taken.
module tb_ram_sdp_param;

  logic clk;
  logic rst_n;

  logic        a_wr_en, a_rd_en;
  logic [3:0]  a_wr_addr, a_rd_addr;
  logic [7:0]  a_wr_data, a_rd_data;
  logic [0:0]  a_wr_be;
  logic        a_rd_valid, a_init_busy, a_parity_err;

  logic        b_wr_en, b_rd_en;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data;
  logic [3:0]  b_wr_be;
  logic        b_rd_valid, b_init_busy, b_parity_err;

  int checks   = 0;
  int failures = 0;

  ram_sdp_param #(.DATA_W(8), .DEPTH(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .init_busy(a_init_busy), .parity_err(a_parity_err)
  );

  ram_sdp_param #(.DATA_W(32), .DEPTH(12)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .init_busy(b_init_busy), .parity_err(b_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;       // 0: 8-bit instance, 1: 32-bit instance
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_addr = 4'h0; a_rd_addr = 4'h0;
    a_wr_data = 8'h00; a_wr_be = 1'b0;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_addr = 4'h0; b_rd_addr = 4'h0;
    b_wr_data = 32'h0; b_wr_be = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until the 8-bit instance leaves clear (32-bit one sampled too).
  task automatic wait_clear(output int first8, output int first32, output int stray_valid);
    first8 = 0; first32 = 0; stray_valid = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (a_rd_valid || b_rd_valid) stray_valid++;
      if (first32 == 0 && !b_init_busy) first32 = c;
      if (!a_init_busy) begin
        first8 = c;
        break;
      end
    end
    idle_inputs();
  endtask

  task automatic read8(input string nm, input logic [3:0] addr, input logic [7:0] exp);
    a_rd_en = 1'b1; a_rd_addr = addr;
    step();
    a_rd_en = 1'b0;
    chk({nm, "_valid"}, {31'h0, a_rd_valid}, 32'h1);
    chk({nm, "_data"}, {24'h0, a_rd_data}, {24'h0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f8, f32, stray;

    vecs[0]  = '{1'b0, 1'b1, 4'h0, 32'h000000AA, 4'h1, 1'b0, 4'h0, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 4'h1, 32'h00000055, 4'h1, 1'b0, 4'h0, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h0, 1'b1, 32'hAA};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h1, 1'b1, 32'h55};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, 32'h55};
    vecs[5]  = '{1'b0, 1'b1, 4'h5, 32'h00000077, 4'h1, 1'b1, 4'h5, 1'b1, 32'h00};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h5, 1'b1, 32'h77};
    vecs[7]  = '{1'b0, 1'b1, 4'h1, 32'h000000FF, 4'h0, 1'b0, 4'h0, 1'b0, 32'h77};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h1, 1'b1, 32'h55};
    vecs[9]  = '{1'b1, 1'b1, 4'h3, 32'hDEADBEEF, 4'hF, 1'b0, 4'h0, 1'b0, 32'h00000000};
    vecs[10] = '{1'b1, 1'b1, 4'h3, 32'h00001234, 4'h3, 1'b0, 4'h0, 1'b0, 32'h00000000};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h3, 1'b1, 32'hDEAD1234};
    vecs[12] = '{1'b1, 1'b1, 4'h3, 32'h11FFFFFF, 4'h8, 1'b0, 4'h0, 1'b0, 32'hDEAD1234};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h3, 1'b1, 32'h11AD1234};
    vecs[14] = '{1'b1, 1'b1, 4'hC, 32'hFFFFFFFF, 4'hF, 1'b0, 4'h0, 1'b0, 32'h11AD1234};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'hC, 1'b1, 32'h00000000};
    vecs[16] = '{1'b1, 1'b1, 4'hB, 32'hCAFEF00D, 4'hF, 1'b0, 4'h0, 1'b0, 32'h00000000};
    vecs[17] = '{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'hB, 1'b1, 32'hCAFEF00D};
    vecs[18] = '{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h0, 1'b1, 32'h00000000};
    vecs[19] = '{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'hF, 1'b1, 32'h00000000};

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_rd_data",  {24'h0, a_rd_data}, 32'h0);
    chk("rst_rd_valid", {31'h0, a_rd_valid}, 32'h0);
    chk("rst_busy8",    {31'h0, a_init_busy}, 32'h1);
    chk("rst_busy32",   {31'h0, b_init_busy}, 32'h1);
    chk("rst_perr",     {31'h0, a_parity_err}, 32'h0);

    // Clear sequence with requests that must be dropped
    rst_n = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 4'h0; a_wr_data = 8'hAA; a_wr_be = 1'b1;
    a_rd_en = 1'b1; a_rd_addr = 4'h0;
    wait_clear(f8, f32, stray);
    chk("clear_len8",  f8, 32'd16);
    chk("clear_len32", f32, 32'd12);
    chk("clear_no_valid", stray, 32'd0);
    step();
    chk("ready_stays", {31'h0, a_init_busy}, 32'h0);
    chk("ready_idle_valid", {31'h0, a_rd_valid}, 32'h0);

    // All words zero after clear (write during clear lost)
    for (int i = 0; i < 16; i++) read8($sformatf("clr_rd%0d", i), 4'(i), 8'h00);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].sel == 1'b0) begin
        a_wr_en = vecs[i].wr_en; a_wr_addr = vecs[i].wr_addr;
        a_wr_data = vecs[i].wr_data[7:0]; a_wr_be = vecs[i].wr_be[0:0];
        a_rd_en = vecs[i].rd_en; a_rd_addr = vecs[i].rd_addr;
      end else begin
        b_wr_en = vecs[i].wr_en; b_wr_addr = vecs[i].wr_addr;
        b_wr_data = vecs[i].wr_data; b_wr_be = vecs[i].wr_be;
        b_rd_en = vecs[i].rd_en; b_rd_addr = vecs[i].rd_addr;
      end
      step();
      idle_inputs();
      if (vecs[i].sel == 1'b0) begin
        chk($sformatf("vec%0d_valid", i), {31'h0, a_rd_valid}, {31'h0, vecs[i].exp_valid});
        chk($sformatf("vec%0d_data", i), {24'h0, a_rd_data}, {24'h0, vecs[i].exp_data[7:0]});
        chk($sformatf("vec%0d_perr", i), {31'h0, a_parity_err}, 32'h0);
      end else begin
        chk($sformatf("vec%0d_valid", i), {31'h0, b_rd_valid}, {31'h0, vecs[i].exp_valid});
        chk($sformatf("vec%0d_data", i), b_rd_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_perr", i), {31'h0, b_parity_err}, 32'h0);
      end
    end

    // Reset during operation, then again at clear cycle 7
    rst_n = 1'b0;
    #1;
    chk("midop_rst_busy",  {31'h0, a_init_busy}, 32'h1);
    chk("midop_rst_data",  {24'h0, a_rd_data}, 32'h0);
    step();
    rst_n = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 4'h2; a_wr_data = 8'h99; a_wr_be = 1'b1;
    repeat (7) step();
    rst_n = 1'b0;
    #2;
    chk("midclr_rst_busy", {31'h0, a_init_busy}, 32'h1);
    rst_n = 1'b1;
    wait_clear(f8, f32, stray);
    chk("restart_len8",  f8, 32'd16);
    chk("restart_len32", f32, 32'd12);
    chk("restart_no_valid", stray, 32'd0);
    read8("post_rst_rd5", 4'h5, 8'h00);
    read8("post_rst_rd0", 4'h0, 8'h00);
    read8("post_rst_rd2", 4'h2, 8'h00);

`ifdef RAM_PARITY_EN
    begin
      logic [8:0] w;
      a_wr_en = 1'b1; a_wr_addr = 4'h2; a_wr_data = 8'h3C; a_wr_be = 1'b1;
      step();
      idle_inputs();
      read8("par_clean", 4'h2, 8'h3C);
      chk("par_clean_perr", {31'h0, a_parity_err}, 32'h0);
      w = u_dut8.mem_r[2];
      w[0] = ~w[0];
      u_dut8.mem_r[2] = w;
      read8("par_flip", 4'h2, 8'h3D);
      chk("par_flip_perr", {31'h0, a_parity_err}, 32'h1);
      read8("par_other", 4'h0, 8'h00);
      chk("par_other_perr", {31'h0, a_parity_err}, 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
